// File: rtl/aes_mixstate_iter.sv
// Iterative MixColumns / InvMixColumns engine for a 128-bit AES state.
// Mixes COLS_PER_CYCLE columns per cycle in place, then holds the result until it is consumed.
module aes_mixstate_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dec,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  input  logic         flush
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("aes_mixstate_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] CTR_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CTR_LAST = 2'(4 - COLS_PER_CYCLE);

  state_t       state_reg, state_next;
  logic [127:0] work_reg, work_next;
  logic [1:0]   ctr_reg, ctr_next;
  logic         dec_reg, dec_next;
  logic         last_group;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Every coefficient is built from a, 2a, 4a and 8a.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic dec);
    logic [3:0][7:0] a, m2, m4, m8;
    logic [31:0]     res;
    res = '0;
    a   = c;
    for (int r = 0; r < 4; r++) begin
      m2[r] = xt(a[r]);
      m4[r] = xt(m2[r]);
      m8[r] = xt(m4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      logic [1:0] r0, r1, r2, r3;
      r0 = 2'(r);
      r1 = r0 + 2'd1;
      r2 = r0 + 2'd2;
      r3 = r0 + 2'd3;
      if (dec)
        res[8*r +: 8] = (m8[r0] ^ m4[r0] ^ m2[r0])
                      ^ (m8[r1] ^ m2[r1] ^ a[r1])
                      ^ (m8[r2] ^ m4[r2] ^ a[r2])
                      ^ (m8[r3] ^ a[r3]);
      else
        res[8*r +: 8] = m2[r0] ^ (m2[r1] ^ a[r1]) ^ a[r2] ^ a[r3];
    end
    return res;
  endfunction

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_mix [COLS_PER_CYCLE];

  genvar gi;
  generate
    for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
      assign col_idx[gi] = ctr_reg + 2'(gi);
      assign col_mix[gi] = mix_col(work_reg[32*col_idx[gi] +: 32], dec_reg);
    end
  endgenerate

  assign last_group = (ctr_reg == CTR_LAST);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      ctr_reg   <= '0;
      dec_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      ctr_reg   <= ctr_next;
      dec_reg   <= dec_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (in_valid) state_next = BUSY;
        BUSY:    if (last_group) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Flush leaves the work register alone; only control state is cleared.
  always_comb begin
    work_next = work_reg;
    ctr_next  = ctr_reg;
    dec_next  = dec_reg;
    if (flush) begin
      ctr_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_next = in_state;
            dec_next  = in_dec;
            ctr_next  = '0;
          end
        end
        BUSY: begin
          for (int k = 0; k < COLS_PER_CYCLE; k++)
            work_next[32*col_idx[k] +: 32] = col_mix[k];
          ctr_next = ctr_reg + CTR_STEP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg == BUSY) || (state_reg == DONE);
  end

  assign out_state = work_reg;

endmodule

// File: doc/aes_mixstate_iter.md
Name: aes_mixstate_iter

Overview:
Multi-cycle MixColumns / InvMixColumns engine for a full 128-bit AES state (or a round key, for equivalent-inverse-cipher key preparation). It accepts a state over a valid/ready handshake and processes COLS_PER_CYCLE columns per cycle through internal per-column mix logic (forward or inverse, selected per transaction). It presents the registered result over a second valid/ready handshake. It sits between the SubBytes/ShiftRows stage and the AddRoundKey stage of the round datapath, and also serves the decryption key-schedule path.

Parameters:
COLS_PER_CYCLE, 1, columns mixed per cycle; legal values 1, 2, 4; any other value is an elaboration error. Internal column-mix instances = COLS_PER_CYCLE.

Ports:
g_clk  input  1  clock, rising edge
g_resetn  input  1  asynchronous active-low reset
in_valid  input  1  input state valid
in_ready  output  1  block can accept a state
in_dec  input  1  1 = InvMixColumns, 0 = MixColumns; sampled on input handshake
in_state  input  128  column i = bits [32i+31:32i]; row r of a column = bits [8r+7:8r]
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_state  output  128  mixed state, same layout as in_state
busy  output  1  high in BUSY or DONE
flush  input  1  synchronous abort

Behaviour:
- Reset (g_resetn low, asynchronous): FSM = IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, column counter=0, dec register=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_state into the work register and in_dec into the dec register, clear the column counter, and go to BUSY.
- BUSY: in_ready=0, busy=1. Each cycle, mix columns ctr..ctr+COLS_PER_CYCLE-1 of the work register in place (forward or inverse per the latched dec), and advance ctr by COLS_PER_CYCLE. ctr is 2 bits and wraps naturally. When the last column group is written, go to DONE.
- Latency: input handshake at edge E; out_valid is high after edge E + 4/COLS_PER_CYCLE (4, 2 or 1 cycles).
- DONE: out_valid=1 and out_state = the work register, held stable while out_ready=0 (no change in value or valid). On out_ready, go to IDLE at the next edge, with out_valid=0 and in_ready=1. There is no same-cycle accept in DONE: the minimum gap between two input accepts is latency + 2 cycles.
- out_state is driven from the work register at all times. Its value is only meaningful while out_valid=1. Verification must not check it otherwise.
- Per-column math:
  - Forward: o_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3).
  - Inverse: o_r = e·a_r ^ b·a_(r+1) ^ d·a_(r+2) ^ 9·a_(r+3).
  - Row indices are taken mod 4. Arithmetic is in GF(2^8) with reduction polynomial 0x11b.
- The input is unconstrained while in_ready=0. in_valid during BUSY/DONE is ignored and nothing is queued.
- flush: highest priority after reset. In any state, the next edge gives FSM=IDLE, out_valid=0, ctr=0, and the work register is left unchanged. If flush and in_valid are both high in IDLE, flush wins and no accept occurs. If flush and out_ready are both high in DONE, the result is the same: IDLE.
- Reset asserted mid-operation: immediate return to reset values with no output handshake; a new transaction after reset deasserts behaves normally.
- The dec value is fixed for the whole transaction. Changing in_dec after accept has no effect.

Test Plan:
- Forward, COLS_PER_CYCLE=1: in_state column words {0x455313db, 0x5c220af2, 0x01010101, 0xc6c6c6c6} (col0..col3), in_dec=0 -> after 4 cycles out_state columns {0xbca14d8e, 0x9d58dc9f, 0x01010101, 0xc6c6c6c6}.
- Inverse round trip: feed the forward output back with in_dec=1 -> out_state equals the original input. Repeat for COLS_PER_CYCLE=2 and 4, checking latency of 2 and 1 cycles respectively.
- Output backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_state stable, in_ready=0, in_valid pulses ignored; release -> IDLE the next cycle.
- Flush: flush in the 2nd BUSY cycle -> IDLE next edge, out_valid never asserts; the next transaction produces the correct result. Flush+in_valid in IDLE -> no accept.
- Async reset mid-BUSY: drop g_resetn between edges -> outputs take reset values immediately (out_valid=0, in_ready=1, out_state=0) without waiting for a clock.
- Random: 1000 back-to-back transactions with random dec and random out_ready stalls, compared against a reference model. The bench checks that the result count equals the accept count and that order is preserved.
